// File: rtl/bus_pkg.sv
// bus_pkg: shared opcode/state encodings and beat-count helper for the pin bus bridge.
package bus_pkg;
  typedef enum logic [2:0] {BusNone = 3'd0, BusRead = 3'd1, BusWrite = 3'd2} BusOp;
  typedef enum logic [2:0] {IDLE, OPCODE, ADDR, DATA, RESP} IoState;
  function automatic int beats(input int width, input int pin_w);
    return (width + pin_w - 1) / pin_w;
  endfunction
endpackage

// File: rtl/beat_shift.sv
// beat_shift: loadable word shifter presenting its top PIN_W bits as the current beat.
module beat_shift #(
  parameter int PIN_W = 8,
  parameter int BEATS = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   shift,
  input  logic [BEATS*PIN_W-1:0] load_word,
  input  logic [PIN_W-1:0]       shift_in,
  output logic [PIN_W-1:0]       beat,
  output logic [BEATS*PIN_W-1:0] word
);
  localparam int W = BEATS * PIN_W;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) word <= '0;
    else if (load) word <= load_word;
    else if (shift) word <= W'({word, shift_in});
  assign beat = word[W-1 -: PIN_W];
endmodule

// File: rtl/pin_bus_bridge.sv
// pin_bus_bridge: serialises core requests onto a narrow pin bus (opcode, address, data beats).
// Define BUS_TIMEOUT_EN to abort stalled data beats after TIMEOUT_CYCLES with rsp_err.
module pin_bus_bridge
  import bus_pkg::*;
#(
  parameter int PIN_W          = 8,
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  BusOp              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [PIN_W-1:0]  pin_out,
  input  logic [PIN_W-1:0]  pin_in,
  input  logic              op_done,
  output logic [2:0]        pin_state,
  output logic              busy
);
  localparam int AB = beats(ADDR_W, PIN_W);
  localparam int DB = beats(DATA_W, PIN_W);
  localparam int MB = AB > DB ? AB : DB;
  localparam int CW = $clog2(MB + 1);
  IoState state, state_n;
  BusOp op;
  logic [CW-1:0] cnt;
  logic err, accept, beat_ok, addr_last, data_last, tout;
  logic [PIN_W-1:0] addr_beat, data_beat;
  logic [AB*PIN_W-1:0] addr_word;
  logic [DB*PIN_W-1:0] data_word;
  assign accept    = state == IDLE && req_valid && enable && req_op != BusNone;
  assign beat_ok   = state == DATA && op_done && enable;
  assign addr_last = cnt == CW'(AB - 1);
  assign data_last = cnt == CW'(DB - 1);
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  // an op_done on the limit cycle is accepted, so the limit only fires without one
  assign tout = state == DATA && enable && !op_done && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else if (enable) tcnt <= (state != DATA || op_done || tout) ? '0 : tcnt + 1'b1;
`else
  assign tout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    if (enable)
      unique case (state)
        IDLE:    state_n = accept ? OPCODE : IDLE;
        OPCODE:  state_n = ADDR;
        ADDR:    state_n = addr_last ? DATA : ADDR;
        DATA:    state_n = (beat_ok && data_last) || tout ? RESP : DATA;
        RESP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= BusNone;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      if (enable) begin
        cnt <= state_n != state ? '0 : (state == ADDR || beat_ok) ? cnt + 1'b1 : cnt;
        if (accept) begin
          op  <= req_op;
          err <= 1'b0;
        end else if (tout) err <= 1'b1;
      end
    end
  beat_shift #(.PIN_W(PIN_W), .BEATS(AB)) u_addr (
    .clock(clock), .reset_n(reset_n), .load(accept), .shift(enable && state == ADDR),
    .load_word((AB*PIN_W)'(req_addr)), .shift_in('0), .beat(addr_beat), .word(addr_word)
  );
  // read beats enter from the bottom, so after DB beats the word holds the read data
  beat_shift #(.PIN_W(PIN_W), .BEATS(DB)) u_data (
    .clock(clock), .reset_n(reset_n), .load(accept), .shift(beat_ok),
    .load_word((DB*PIN_W)'(req_wdata)), .shift_in(pin_in), .beat(data_beat), .word(data_word)
  );
  assign req_ready = state == IDLE && enable;
  assign pin_out   = state == OPCODE ? PIN_W'(op) :
                     state == ADDR ? addr_beat :
                     state == DATA && op == BusWrite ? data_beat : '0;
  assign rsp_valid = state == RESP;
  assign rsp_err   = rsp_valid && err;
  assign rsp_rdata = rsp_valid && op == BusRead && !err ? data_word[DATA_W-1:0] : '0;
  assign pin_state = state;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_pin_bus_bridge.sv
// tb_pin_bus_bridge: directed bench with response scoreboards for a default and a 4-bit-pin bridge.
module tb_pin_bus_bridge;
  import bus_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic rv = 1'b0, rr, rsv, rer, od = 1'b0, bz;
  BusOp rop = BusNone;
  logic [14:0] raddr = '0;
  logic [7:0] rwd = '0, rrd, po, pi = '0;
  logic [2:0] ps;
  logic rv1 = 1'b0, rr1, rsv1, rer1, od1 = 1'b0, bz1;
  BusOp rop1 = BusNone;
  logic [14:0] ra1 = '0;
  logic [9:0] rw1 = '0, rrd1;
  logic [3:0] po1, pi1 = '0;
  logic [2:0] ps1;
  int checks = 0, errors = 0, rsp_seen = 0, base = 0;
  logic [8:0] q0[$];
  logic [10:0] q1[$];
  logic [8:0] e0;
  logic [10:0] e1;
  always #5 clk = ~clk;
  pin_bus_bridge #(.TIMEOUT_CYCLES(8)) dut0 (
    .clock(clk), .reset_n(rst_n), .enable(en), .req_valid(rv), .req_ready(rr), .req_op(rop),
    .req_addr(raddr), .req_wdata(rwd), .rsp_valid(rsv), .rsp_rdata(rrd), .rsp_err(rer),
    .pin_out(po), .pin_in(pi), .op_done(od), .pin_state(ps), .busy(bz)
  );
  pin_bus_bridge #(.PIN_W(4), .DATA_W(10)) dut1 (
    .clock(clk), .reset_n(rst_n), .enable(en), .req_valid(rv1), .req_ready(rr1), .req_op(rop1),
    .req_addr(ra1), .req_wdata(rw1), .rsp_valid(rsv1), .rsp_rdata(rrd1), .rsp_err(rer1),
    .pin_out(po1), .pin_in(pi1), .op_done(od1), .pin_state(ps1), .busy(bz1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic nb();
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (rsv === 1'b1) begin
      rsp_seen++;
      chk("rsp0_pending", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        chk("rsp0_err", rer, e0[8]);
        chk("rsp0_rdata", rrd, e0[7:0]);
      end
    end
    if (rsv1 === 1'b1) begin
      chk("rsp1_pending", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        chk("rsp1_err", rer1, e1[10]);
        chk("rsp1_rdata", rrd1, e1[9:0]);
      end
    end
  end
  initial begin
    #1;
    chk("rst_pin_out", po, 0);
    chk("rst_rsp_valid", rsv, 0);
    chk("rst_rsp_err", rer, 0);
    chk("rst_busy", bz, 0);
    chk("rst_state", ps, IDLE);
    chk("rst_ready_en", rr, 1);
    en = 1'b0; #1;
    chk("rst_ready_dis", rr, 0);
    en = 1'b1;
    nb(); nb(); rst_n = 1'b1;
    nb();
    // BusNone is consumed and dropped
    rv = 1'b1; rop = BusNone; #1;
    chk("none_ready", rr, 1);
    nb(); rv = 1'b0; #1;
    chk("none_dropped", bz, 0);
    // write 0x1234 / 0xA5 with op_done high
    rv = 1'b1; rop = BusWrite; raddr = 15'h1234; rwd = 8'hA5; od = 1'b1; q0.push_back({1'b0, 8'h00}); #1;
    chk("wr_ready", rr, 1);
    nb(); rv = 1'b0;
    chk("wr_opcode", po, 8'h02); chk("wr_st_op", ps, OPCODE);
    nb(); chk("wr_addr_hi", po, 8'h12); chk("wr_st_addr", ps, ADDR);
    nb(); chk("wr_addr_lo", po, 8'h34);
    nb(); chk("wr_data", po, 8'hA5); chk("wr_st_data", ps, DATA);
    nb(); chk("wr_latency", rsv, 1);
    nb(); chk("wr_idle", bz, 0);
    // read 0x7FFF, op_done delayed
    od = 1'b0; rv = 1'b1; rop = BusRead; raddr = 15'h7FFF; pi = 8'h3C; q0.push_back({1'b0, 8'h3C});
    base = rsp_seen;
    nb(); rv = 1'b0; chk("rd_opcode", po, 8'h01);
    nb(); chk("rd_addr_hi", po, 8'h7F);
    nb(); chk("rd_addr_lo", po, 8'hFF);
    nb(); chk("rd_data_pin", po, 8'h00); chk("rd_st_data", ps, DATA);
    repeat (3) begin nb(); chk("rd_wait", ps, DATA); end
    od = 1'b1;
    nb(); od = 1'b0; chk("rd_rsp", rsv, 1);
    repeat (3) nb();
    chk("rd_once", rsp_seen - base, 1);
    // enable dropped mid-address
    od = 1'b1; rv = 1'b1; rop = BusWrite; raddr = 15'h5678; rwd = 8'h3C; q0.push_back({1'b0, 8'h00});
    nb(); rv = 1'b0; chk("en_opcode", po, 8'h02);
    nb(); chk("en_addr_hi", po, 8'h56); en = 1'b0;
    repeat (3) begin nb(); chk("en_frozen_pin", po, 8'h56); chk("en_frozen_st", ps, ADDR); end
    en = 1'b1;
    nb(); chk("en_addr_lo", po, 8'h78);
    nb(); chk("en_data", po, 8'h3C);
    nb(); chk("en_rsp", rsv, 1);
    nb();
    // reset during DATA abandons the op
    od = 1'b0; rv = 1'b1; rop = BusWrite; raddr = 15'h0001; rwd = 8'h77;
    nb(); rv = 1'b0;
    nb(); nb(); nb();
    chk("rs_st_data", ps, DATA); chk("rs_pin_data", po, 8'h77);
    rst_n = 1'b0; #1;
    chk("rs_busy", bz, 0); chk("rs_pin", po, 0); chk("rs_state", ps, IDLE);
    nb(); rst_n = 1'b1; base = rsp_seen; od = 1'b1;
    repeat (6) nb();
    chk("rs_no_rsp", rsp_seen - base, 0);
    od = 1'b0;
    // 4-bit pins, 10-bit data read
    rv1 = 1'b1; rop1 = BusRead; ra1 = 15'h1234; q1.push_back({1'b0, 10'h2B7});
    nb(); rv1 = 1'b0; chk("n_opcode", po1, 4'h1);
    nb(); chk("n_addr0", po1, 4'h1);
    nb(); chk("n_addr1", po1, 4'h2);
    nb(); chk("n_addr2", po1, 4'h3);
    nb(); chk("n_addr3", po1, 4'h4); pi1 = 4'h2; od1 = 1'b1;
    nb(); chk("n_st_data", ps1, DATA);
    nb(); pi1 = 4'hB;
    nb(); pi1 = 4'h7;
    nb(); od1 = 1'b0; chk("n_rsp", rsv1, 1);
    nb();
`ifdef BUS_TIMEOUT_EN
    rv = 1'b1; rop = BusRead; raddr = 15'h0000; q0.push_back({1'b1, 8'h00});
    nb(); rv = 1'b0;
    nb(); nb();
    repeat (8) begin nb(); chk("to_wait", ps, DATA); end
    nb(); chk("to_rsp", rsv, 1); chk("to_err", rer, 1);
    nb();
    rv = 1'b1; q0.push_back({1'b0, 8'h99});
    nb(); rv = 1'b0;
    nb(); nb();
    repeat (8) begin nb(); chk("tl_wait", ps, DATA); end
    od = 1'b1; pi = 8'h99;
    nb(); od = 1'b0; chk("tl_rsp", rsv, 1); chk("tl_err", rer, 0);
    nb();
`endif
    repeat (3) nb();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
